wallace8_spst_mult_pipe3: RTL and testbench

//  Unsigned 8x8 -> 16-bit streaming multiplier for the AXI-Stream DSP datapath.

---
 rtl/wallace8_spst_mult_pipe3_if.sv | 23 ++
 rtl/wallace8_spst_mult_pipe3.sv | 138 +++++++++++++
 tb/tb_wallace8_spst_mult_pipe3.sv | 177 +++++++++++++++++
 3 files changed

// File: rtl/wallace8_spst_mult_pipe3_if.sv
// Streaming operand/product bus for wallace8_spst_mult_pipe3.
//   en      : input-valid strobe (master -> slave)
//   a_i     : 8-bit unsigned multiplicand (master -> slave)
//   b_i     : 8-bit unsigned multiplier (master -> slave)
//   p_o     : 16-bit unsigned product (slave -> master)
//   valid_o : p_o holds a fresh product this cycle (slave -> master)
interface wallace8_spst_mult_pipe3_if;
    logic        en;
    logic [7:0]  a_i;
    logic [7:0]  b_i;
    logic [15:0] p_o;
    logic        valid_o;

    modport master (
        output en, a_i, b_i,
        input  p_o, valid_o
    );

    modport slave (
        input  en, a_i, b_i,
        output p_o, valid_o
    );
endinterface

// File: rtl/wallace8_spst_mult_pipe3.sv
// Unsigned 8x8 -> 16 streaming multiplier, three register stages:
// operand capture, Wallace carry-save reduction, final carry-propagate add.
// Registers that would carry no useful work are frozen (zero operands,
// all-zero upper nibbles) without changing the product seen on p_o.
//   clk : rising-edge clock
//   rst : asynchronous active-high reset
//   bus : slave side of wallace8_spst_mult_pipe3_if (en/a_i/b_i in, p_o/valid_o out)
module wallace8_spst_mult_pipe3 (
    input  logic                        clk,
    input  logic                        rst,
    wallace8_spst_mult_pipe3_if.slave   bus
);
    localparam int unsigned OP_W  = 8;
    localparam int unsigned NIB_W = 4;
    localparam int unsigned P_W   = 16;

    // 3:2 compressor across a whole row: returns {carry << 1, sum}
    function automatic logic [2*P_W-1:0] csa(
        input logic [P_W-1:0] x,
        input logic [P_W-1:0] y,
        input logic [P_W-1:0] z
    );
        logic [P_W-1:0] s;
        logic [P_W-1:0] c;
        s = x ^ y ^ z;
        c = ((x & y) | (x & z) | (y & z)) << 1;
        return {c, s};
    endfunction

    // ---------------- S1: operand capture ----------------
    logic             zero_in_c;
    logic             hz_in_c;
    logic [NIB_W-1:0] a_lo, b_lo, a_hi, b_hi;
    logic             v1, zero1, hz1;

    assign zero_in_c = (bus.a_i == '0) || (bus.b_i == '0);
    assign hz_in_c   = (bus.a_i[OP_W-1:NIB_W] == '0) && (bus.b_i[OP_W-1:NIB_W] == '0);

    // Upper nibbles only reload when they are non-zero, so the upper
    // partial-product rows stay quiet through runs of small operands.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_lo  <= '0;
            b_lo  <= '0;
            a_hi  <= '0;
            b_hi  <= '0;
            v1    <= 1'b0;
            zero1 <= 1'b0;
            hz1   <= 1'b0;
        end else begin
            v1 <= bus.en;
            if (bus.en) begin
                a_lo  <= bus.a_i[NIB_W-1:0];
                b_lo  <= bus.b_i[NIB_W-1:0];
                zero1 <= zero_in_c;
                hz1   <= hz_in_c;
                if (!hz_in_c) begin
                    a_hi <= bus.a_i[OP_W-1:NIB_W];
                    b_hi <= bus.b_i[OP_W-1:NIB_W];
                end
            end
        end
    end

    // ---------------- S2: partial products + Wallace reduction ----------------
    logic [OP_W-1:0] a_full, b_full;
    logic [P_W-1:0]  row [OP_W];
    logic [P_W-1:0]  lrow [NIB_W];
    logic [P_W-1:0]  s10, c10, s11, c11, s20, c20, s21, c21, s30, c30, full_s, full_c;
    logic [P_W-1:0]  ls1, lc1, lo_s, lo_c;

    assign a_full = {a_hi, a_lo};
    assign b_full = {b_hi, b_lo};

    // Full 8-row tree: 8 -> 6 -> 4 -> 3 -> 2 rows
    always_comb begin
        for (int unsigned j = 0; j < OP_W; j++) begin
            row[j] = b_full[j] ? (P_W'(a_full) << j) : '0;
        end
        {c10, s10}       = csa(row[0], row[1], row[2]);
        {c11, s11}       = csa(row[3], row[4], row[5]);
        {c20, s20}       = csa(s10, c10, s11);
        {c21, s21}       = csa(c11, row[6], row[7]);
        {c30, s30}       = csa(s20, c20, s21);
        {full_c, full_s} = csa(s30, c30, c21);
    end

    // Low-nibble 4x4 tree used when both upper nibbles are zero: 4 -> 3 -> 2
    always_comb begin
        for (int unsigned j = 0; j < NIB_W; j++) begin
            lrow[j] = b_lo[j] ? (P_W'(a_lo) << j) : '0;
        end
        {lc1, ls1}   = csa(lrow[0], lrow[1], lrow[2]);
        {lo_c, lo_s} = csa(ls1, lc1, lrow[3]);
    end

    logic [P_W-1:0] sum2, carry2;
    logic           v2, zero2;

    // sum/carry hold whenever the product is known to be zero
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sum2   <= '0;
            carry2 <= '0;
            v2     <= 1'b0;
            zero2  <= 1'b0;
        end else begin
            v2 <= v1;
            if (v1) begin
                zero2 <= zero1;
                if (!zero1) begin
                    sum2   <= hz1 ? lo_s : full_s;
                    carry2 <= hz1 ? lo_c : full_c;
                end
            end
        end
    end

    // ---------------- S3: final carry-propagate add ----------------
    logic [P_W-1:0] p_q;
    logic           valid_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            p_q     <= '0;
            valid_q <= 1'b0;
        end else begin
            valid_q <= v2;
            if (v2) begin
                p_q <= zero2 ? '0 : P_W'(sum2 + carry2);
            end
        end
    end

    assign bus.p_o     = p_q;
    assign bus.valid_o = valid_q;

endmodule

// File: tb/tb_wallace8_spst_mult_pipe3.sv
// Self-checking bench for wallace8_spst_mult_pipe3: directed table stream,
// SPST corner pairs, bubble and mid-stream reset sequences, then random
// traffic against a queue-based model of an exact a*b with 2-edge latency.
module tb_wallace8_spst_mult_pipe3;
    logic clk;
    logic rst;

    wallace8_spst_mult_pipe3_if bus ();

    wallace8_spst_mult_pipe3 dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [7:0]  a;
        logic [7:0]  b;
        logic [15:0] p;
    } vec_t;

    typedef struct {
        int          due;
        logic [15:0] p;
    } pend_t;

    int          n_cmp  = 0;
    int          n_fail = 0;
    int          cyc    = 0;
    pend_t       pq[$];
    logic [15:0] last_p = 16'h0000;

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at cycle %0d: got %0d (0x%h), expected %0d (0x%h)",
                     name, cyc, act, act, exp, exp);
        end
    endtask

    // Model: a pair accepted at edge k shows up after edge k+2; otherwise
    // valid_o is low and p_o holds the last product (0 after reset).
    task automatic model_check(input string tag);
        if (pq.size() != 0 && pq[0].due == cyc) begin
            last_p = pq[0].p;
            void'(pq.pop_front());
            chk({tag, ".valid"}, 16'(bus.valid_o), 16'd1);
            chk({tag, ".p"}, bus.p_o, last_p);
        end else begin
            chk({tag, ".valid"}, 16'(bus.valid_o), 16'd0);
            chk({tag, ".p_hold"}, bus.p_o, last_p);
        end
    endtask

    task automatic step(input logic e, input logic [7:0] a, input logic [7:0] b, input string tag);
        pend_t n;
        bus.en  = e;
        bus.a_i = a;
        bus.b_i = b;
        @(posedge clk);
        cyc++;
        if (e && !rst) begin
            n.due = cyc + 2;
            n.p   = 16'(a) * 16'(b);
            pq.push_back(n);
        end
        #1;
        model_check(tag);
    endtask

    vec_t tbl[10];

    initial begin
        tbl[0] = '{8'd0,   8'd0,   16'd0};
        tbl[1] = '{8'd1,   8'd255, 16'd255};
        tbl[2] = '{8'd255, 8'd1,   16'd255};
        tbl[3] = '{8'd128, 8'd2,   16'd256};
        tbl[4] = '{8'd85,  8'd170, 16'd14450};
        tbl[5] = '{8'd15,  8'd15,  16'd225};
        tbl[6] = '{8'd200, 8'd50,  16'd10000};
        tbl[7] = '{8'd7,   8'd13,  16'd91};
        tbl[8] = '{8'd100, 8'd0,   16'd0};
        tbl[9] = '{8'd0,   8'd150, 16'd0};

        bus.en  = 1'b0;
        bus.a_i = 8'd0;
        bus.b_i = 8'd0;
        rst     = 1'b1;

        // Reset held two cycles with en toggling
        #1;
        chk("reset0.p", bus.p_o, 16'd0);
        chk("reset0.valid", 16'(bus.valid_o), 16'd0);
        step(1'b1, 8'd9, 8'd9, "reset");
        step(1'b0, 8'd3, 8'd3, "reset");
        step(1'b1, 8'd200, 8'd7, "reset");
        rst = 1'b0;

        // Back-to-back table stream, checked against the table's products
        for (int i = 0; i < 12; i++) begin
            if (i < 10) step(1'b1, tbl[i].a, tbl[i].b, "stream");
            else        step(1'b0, 8'd0, 8'd0, "stream");
            if (i >= 2) begin
                chk("stream.tbl_valid", 16'(bus.valid_o), 16'd1);
                chk("stream.tbl_p", bus.p_o, tbl[i-2].p);
            end
        end
        step(1'b0, 8'd0, 8'd0, "stream_tail");

        // Corner and SPST paths, each right after a non-zero product
        step(1'b1, 8'd3,   8'd5,   "corner");
        step(1'b1, 8'd255, 8'd255, "corner");
        step(1'b1, 8'd3,   8'd5,   "corner");
        step(1'b1, 8'd15,  8'd15,  "corner_hz");
        step(1'b1, 8'd200, 8'd201, "corner");
        step(1'b1, 8'd0,   8'd77,  "corner_zero");
        step(1'b0, 8'd0,   8'd0,   "corner");
        chk("corner.last_hz_zero", bus.p_o, 16'd40200);
        step(1'b0, 8'd0,   8'd0,   "corner");
        chk("corner.zero_after_nonzero", bus.p_o, 16'd0);

        // Bubble: 12, two held cycles, then 81
        step(1'b1, 8'd3, 8'd4, "bubble");
        step(1'b0, 8'd0, 8'd0, "bubble");
        step(1'b0, 8'd0, 8'd0, "bubble");
        chk("bubble.first", bus.p_o, 16'd12);
        step(1'b1, 8'd9, 8'd9, "bubble");
        chk("bubble.hold1", bus.p_o, 16'd12);
        step(1'b0, 8'd0, 8'd0, "bubble");
        chk("bubble.hold2", bus.p_o, 16'd12);
        step(1'b0, 8'd0, 8'd0, "bubble");
        chk("bubble.second", bus.p_o, 16'd81);

        // Reset mid-stream with two products in flight
        step(1'b1, 8'd17, 8'd19, "midrst");
        step(1'b1, 8'd33, 8'd44, "midrst");
        rst = 1'b1;
        #1;
        pq.delete();
        last_p = 16'h0000;
        chk("midrst.valid_now", 16'(bus.valid_o), 16'd0);
        chk("midrst.p_now", bus.p_o, 16'd0);
        step(1'b0, 8'd0, 8'd0, "midrst_hold");
        rst = 1'b0;
        for (int i = 0; i < 3; i++) step(1'b0, 8'd0, 8'd0, "midrst_after");

        // Random traffic, biased towards the gated paths
        for (int i = 0; i < 1000; i++) begin
            logic [7:0] a, b;
            logic       e;
            int unsigned mode;
            e    = ($urandom_range(0, 3) != 0);
            mode = $urandom_range(0, 5);
            a    = 8'($urandom);
            b    = 8'($urandom);
            if (mode == 0) begin
                a[7:4] = 4'd0;
                b[7:4] = 4'd0;
            end else if (mode == 1) begin
                if ($urandom_range(0, 1) == 0) a = 8'd0;
                else                           b = 8'd0;
            end
            step(e, a, b, "random");
        end
        step(1'b0, 8'd0, 8'd0, "flush");
        step(1'b0, 8'd0, 8'd0, "flush");
        step(1'b0, 8'd0, 8'd0, "flush");
        chk("flush.queue_empty", 16'(pq.size()), 16'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
